// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state codes and flag helper shared by the alu_seq slice
package alu_pkg;
    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_AND    = 5'd2,
        OP_OR     = 5'd3,
        OP_XOR    = 5'd4,
        OP_SLL    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_SLT    = 5'd8,
        OP_SLTU   = 5'd9,
        OP_MUL    = 5'd10,
        OP_MULH   = 5'd11,
        OP_MULHU  = 5'd12,
        OP_MULHSU = 5'd13,
        OP_DIV    = 5'd14,
        OP_DIVU   = 5'd15,
        OP_REM    = 5'd16,
        OP_REMU   = 5'd17
    } op_e;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    function automatic logic add_sub_ovf(input logic sub, input logic a_msb, input logic b_msb,
                                         input logic r_msb);
        return sub ? (a_msb != b_msb) && (r_msb != a_msb) : (a_msb == b_msb) && (r_msb != a_msb);
    endfunction
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result valid-ready bus between decode and writeback
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid, in_ready, out_valid, out_ready;
    logic [4:0]       op;
    logic [WIDTH-1:0] op_a, op_b, result;
    logic             carry_out, overflow, negative, zero, div_by_zero;

    modport master (
        output in_valid, op, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, carry_out, overflow, negative, zero, div_by_zero
    );
    modport slave (
        input  in_valid, op, op_a, op_b, out_ready,
        output in_ready, out_valid, result, carry_out, overflow, negative, zero, div_by_zero
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: one-bit-per-cycle shift-add multiplier and restoring divider
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH) + 1;
    logic                   busy, is_div, is_rem, hi, neg_q, neg_r, sa, sb, div_src;
    logic [CW-1:0]          cnt;
    logic [WIDTH-1:0]       dv, dv_src, a_mag, b_mag, q, r;
    logic [2*WIDTH-1:0]     acc, acc_src, acc_nxt, prod;
    logic [WIDTH:0]         mul_sum, rem_sh, rem_diff;

    assign sa = a[WIDTH-1] && (op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    assign sb = b[WIDTH-1] && (op inside {OP_MULH, OP_DIV, OP_REM});
    assign a_mag = sa ? -a : a;
    assign b_mag = sb ? -b : b;
    // The start edge already performs the first iteration on the fresh magnitudes.
    assign div_src = start ? (op inside {[OP_DIV:OP_REMU]}) : is_div;
    assign acc_src = start ? {{WIDTH{1'b0}}, a_mag} : acc;
    assign dv_src = start ? b_mag : dv;
    assign mul_sum = {1'b0, acc_src[2*WIDTH-1:WIDTH]} + (acc_src[0] ? {1'b0, dv_src} : '0);
    assign rem_sh = acc_src[2*WIDTH-1:WIDTH-1];
    assign rem_diff = rem_sh - {1'b0, dv_src};
    assign acc_nxt = !div_src ? {mul_sum, acc_src[WIDTH-1:1]} :
                     rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_src[WIDTH-2:0], 1'b0} :
                     {rem_diff[WIDTH-1:0], acc_src[WIDTH-2:0], 1'b1};
    assign done = busy && cnt == CW'(WIDTH);
    assign prod = neg_q ? -acc : acc;
    assign q = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign r = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    assign res = is_div ? (is_rem ? r : q) : (hi ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            dv     <= '0;
            is_div <= 1'b0;
            is_rem <= 1'b0;
            hi     <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            ovf    <= 1'b0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= CW'(1);
            acc    <= acc_nxt;
            dv     <= b_mag;
            is_div <= div_src;
            is_rem <= op inside {OP_REM, OP_REMU};
            hi     <= op inside {OP_MULH, OP_MULHU, OP_MULHSU};
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            ovf    <= op == OP_DIV && a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1;
        end else if (done) begin
            busy <= 1'b0;
        end else if (busy) begin
            cnt <= cnt + 1'b1;
            acc <= acc_nxt;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/flags and iterative mul/div
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    logic [1:0]       state, state_nxt;
    logic             accept, start, dz, ill, md_done, md_ovf, ld, sc_carry, sc_ovf;
    logic [WIDTH-1:0] a, b, sc_res, md_res, nxt_res;
    logic [WIDTH:0]   sum, diff;
    logic [SHW-1:0]   sh;

    assign a = bus.op_a;
    assign b = bus.op_b;
    assign sh = b[SHW-1:0];
    assign sum = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign bus.in_ready = state == IDLE || (state == HOLD && bus.out_ready);
    assign bus.out_valid = state == HOLD;
    assign accept = bus.in_valid && bus.in_ready;
    assign dz = (bus.op inside {[OP_DIV:OP_REMU]}) && b == '0;
    assign start = accept && !dz && (bus.op inside {[OP_MUL:OP_REMU]});
    assign ill = bus.op > OP_REMU;

    always_comb begin
        sc_res = '0;
        case (bus.op)
            OP_ADD:          sc_res = sum[WIDTH-1:0];
            OP_SUB:          sc_res = diff[WIDTH-1:0];
            OP_AND:          sc_res = a & b;
            OP_OR:           sc_res = a | b;
            OP_XOR:          sc_res = a ^ b;
            OP_SLL:          sc_res = a << sh;
            OP_SRL:          sc_res = a >> sh;
            OP_SRA:          sc_res = $signed(a) >>> sh;
            OP_SLT:          sc_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU:         sc_res = {{(WIDTH-1){1'b0}}, a < b};
            OP_DIV, OP_DIVU: sc_res = '1;
            OP_REM, OP_REMU: sc_res = a;
            default:         sc_res = '0;
        endcase
    end

    assign sc_carry = bus.op == OP_ADD ? sum[WIDTH] : bus.op == OP_SUB && !diff[WIDTH];
    assign sc_ovf = (bus.op == OP_ADD || bus.op == OP_SUB) &&
                    add_sub_ovf(bus.op == OP_SUB, a[WIDTH-1], b[WIDTH-1], sc_res[WIDTH-1]);
    assign state_nxt = state == ITER ? (md_done ? HOLD : ITER) :
                       accept ? (start ? ITER : HOLD) :
                       (state == HOLD && !bus.out_ready) ? HOLD : IDLE;
    assign ld = (accept && !start) || md_done;
    assign nxt_res = md_done ? md_res : sc_res;

    alu_muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .op   (bus.op),
        .a    (a),
        .b    (b),
        .done (md_done),
        .res  (md_res),
        .ovf  (md_ovf)
    );

    // During ITER the op/operand inputs are stale, so every flag is gated by md_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            bus.result      <= '0;
            bus.carry_out   <= 1'b0;
            bus.overflow    <= 1'b0;
            bus.negative    <= 1'b0;
            bus.zero        <= 1'b0;
            bus.div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ld) begin
                bus.result      <= nxt_res;
                bus.carry_out   <= !md_done && sc_carry;
                bus.overflow    <= md_done ? md_ovf : sc_ovf;
                bus.negative    <= nxt_res[WIDTH-1];
                bus.zero        <= nxt_res == '0 && (md_done || !ill);
                bus.div_by_zero <= !md_done && dz;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table plus handshake, backpressure and reset sequences
module tb_alu_seq;
    import alu_pkg::*;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a, b, res;
        logic [4:0]  fl;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    vec_t vq[$];

    alu_seq_if #(.WIDTH(32)) bus ();
    alu_seq_if #(.WIDTH(8)) bus8 ();

    alu_seq #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    alu_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] res, input logic [4:0] fl,
                           input int lat);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.res = res; v.fl = fl; v.lat = lat;
        vq.push_back(v);
    endtask

    // Offers one op, then counts edges (accept edge = 1) until out_valid, capped at 100.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic [4:0] fl, output int lat);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = op; bus.op_a = a; bus.op_b = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus.result;
        fl = {bus.carry_out, bus.overflow, bus.negative, bus.zero, bus.div_by_zero};
    endtask

    initial begin
        logic [31:0] r;
        logic [4:0]  f;
        int          lat;
        logic        seen;
        // flags packed as {carry, overflow, negative, zero, div_by_zero}
        add_vec("add_ovf",    OP_ADD,    32'h7FFFFFFF, 32'h1,        32'h80000000, 5'b01100, 1);
        add_vec("sub_eq",     OP_SUB,    32'h5,        32'h5,        32'h0,        5'b10010, 1);
        add_vec("add_carry",  OP_ADD,    32'hFFFFFFFF, 32'h1,        32'h0,        5'b10010, 1);
        add_vec("sub_borrow", OP_SUB,    32'h3,        32'h5,        32'hFFFFFFFE, 5'b00100, 1);
        add_vec("sub_ovf",    OP_SUB,    32'h80000000, 32'h1,        32'h7FFFFFFF, 5'b11000, 1);
        add_vec("and",        OP_AND,    32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 5'b00100, 1);
        add_vec("or",         OP_OR,     32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 5'b00000, 1);
        add_vec("xor",        OP_XOR,    32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 5'b00000, 1);
        add_vec("sll_mask",   OP_SLL,    32'h1,        32'h24,       32'h10,       5'b00000, 1);
        add_vec("srl",        OP_SRL,    32'h80000000, 32'h1F,       32'h1,        5'b00000, 1);
        add_vec("sra",        OP_SRA,    32'h80000000, 32'h4,        32'hF8000000, 5'b00100, 1);
        add_vec("slt",        OP_SLT,    32'hFFFFFFFF, 32'h1,        32'h1,        5'b00000, 1);
        add_vec("sltu",       OP_SLTU,   32'hFFFFFFFF, 32'h1,        32'h0,        5'b00010, 1);
        add_vec("mul",        OP_MUL,    32'hFFFFFFFF, 32'h2,        32'hFFFFFFFE, 5'b00100, 33);
        add_vec("mulhu",      OP_MULHU,  32'hFFFFFFFF, 32'h2,        32'h1,        5'b00000, 33);
        add_vec("mulh",       OP_MULH,   32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 5'b00100, 33);
        add_vec("mulhsu",     OP_MULHSU, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 5'b00100, 33);
        add_vec("mulhsu_ub",  OP_MULHSU, 32'h2,        32'hFFFFFFFF, 32'h1,        5'b00000, 33);
        add_vec("mulhu_big",  OP_MULHU,  32'h80000000, 32'h4,        32'h2,        5'b00000, 33);
        add_vec("mul_small",  OP_MUL,    32'd12345,    32'd678,      32'h007FB6F6, 5'b00000, 33);
        add_vec("div_neg",    OP_DIV,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 5'b00100, 33);
        add_vec("rem_neg",    OP_REM,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 5'b00100, 33);
        add_vec("div_posneg", OP_DIV,    32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 5'b00100, 33);
        add_vec("rem_posneg", OP_REM,    32'h7,        32'hFFFFFFFE, 32'h1,        5'b00000, 33);
        add_vec("divu",       OP_DIVU,   32'd100,      32'd7,        32'd14,       5'b00000, 33);
        add_vec("remu",       OP_REMU,   32'd100,      32'd7,        32'd2,        5'b00000, 33);
        add_vec("divu_dz",    OP_DIVU,   32'h9,        32'h0,        32'hFFFFFFFF, 5'b00101, 1);
        add_vec("rem_dz",     OP_REM,    32'h9,        32'h0,        32'h9,        5'b00001, 1);
        add_vec("div_ovf",    OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 5'b01100, 33);
        add_vec("rem_ovf",    OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0,        5'b00010, 33);
        add_vec("illegal",    5'd20,     32'h5,        32'h5,        32'h0,        5'b00000, 1);

        bus.in_valid = 1'b0; bus.op = '0; bus.op_a = '0; bus.op_b = '0; bus.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.op = '0; bus8.op_a = '0; bus8.op_b = '0; bus8.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_result", bus.result, 32'h0);
        chk("rst_flags", {bus.carry_out, bus.overflow, bus.negative, bus.zero, bus.div_by_zero}, 5'b0);

        foreach (vq[i]) begin
            run_op(vq[i].op, vq[i].a, vq[i].b, r, f, lat);
            chk({vq[i].name, "_res"}, r, vq[i].res);
            chk({vq[i].name, "_flags"}, f, vq[i].fl);
            chk({vq[i].name, "_lat"}, lat, vq[i].lat);
        end

        // Backpressure: result held and in_ready low while out_ready is low.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        run_op(OP_ADD, 32'd2, 32'd3, r, f, lat);
        chk("bp_first_res", r, 32'd5);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_res", bus.result, 32'd5);
            chk("bp_hold_in_ready", bus.in_ready, 1'b0);
            chk("bp_hold_valid", bus.out_valid, 1'b1);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.op = OP_ADD; bus.op_a = 32'd10; bus.op_b = 32'd20;
        #1;
        chk("bp_release_in_ready", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("bp_next_valid", bus.out_valid, 1'b1);
        chk("bp_next_res", bus.result, 32'd30);

        // Reset in the middle of a DIVU, with a competing ADD held on in_valid.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = OP_DIVU; bus.op_a = 32'd1000; bus.op_b = 32'd3;
        @(posedge clk); #1;
        bus.op = OP_ADD;
        seen = 1'b0;
        repeat (9) begin
            @(negedge clk);
            seen |= bus.in_ready | bus.out_valid;
        end
        chk("iter_in_ready_low", seen, 1'b0);
        rst_n = 1'b0;
        #1;
        bus.in_valid = 1'b0;
        chk("mid_rst_out_valid", bus.out_valid, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1'b1);
        chk("post_rst_result", bus.result, 32'h0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen |= bus.out_valid;
        end
        chk("post_rst_no_output", seen, 1'b0);

        // 8-bit instance.
        @(negedge clk);
        bus8.in_valid = 1'b1; bus8.op = OP_SRA; bus8.op_a = 8'h80; bus8.op_b = 8'h3;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        chk("w8_sra_valid", bus8.out_valid, 1'b1);
        chk("w8_sra_res", bus8.result, 8'hF0);
        chk("w8_sra_neg", bus8.negative, 1'b1);
        @(negedge clk);
        bus8.in_valid = 1'b1; bus8.op = OP_MULHU; bus8.op_a = 8'hFF; bus8.op_b = 8'hFF;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        lat = 1;
        while (!bus8.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("w8_mulhu_lat", lat, 9);
        chk("w8_mulhu_res", bus8.result, 8'hFE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
